// File: rtl/fib_seq_engine.sv
// Fibonacci-style sequence engine: F(0)=seed0, F(1)=seed1, F(k)=F(k-1)+F(k-2).
// Returns F(n), or streams every term F(0)..F(n) through a valid/ready handshake.
module fib_seq_engine #(
  parameter int WIDTH    = 16,
  parameter int CNT_W    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] n,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic             stream_mode,
  input  logic             term_ready,
  output logic             busy,
  output logic             term_valid,
  output logic [WIDTH-1:0] term,
  output logic [CNT_W-1:0] term_idx,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a, b;
  logic             a_tag, b_tag;
  logic [CNT_W-1:0] idx, n_q;
  logic             stream_q;
  logic [WIDTH:0]   raw_sum;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             accept, step, last, advance, finish;

  // a holds F(idx), b holds F(idx+1); b is one term ahead, so its tag is not
  // folded into overflow until it has shifted into a and been consumed.
  always_comb begin
    raw_sum = {1'b0, a} + {1'b0, b};
    carry   = raw_sum[WIDTH];
    sum     = (SATURATE && carry) ? {WIDTH{1'b1}} : raw_sum[WIDTH-1:0];
  end

  // abort has priority over any step, including the final one
  always_comb begin
    accept  = (state == IDLE) && start;
    step    = (state == RUN) && !abort && (!stream_q || term_ready);
    last    = (idx == n_q);
    advance = step && !last;
    finish  = step && last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (abort || finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == RUN);
    term_valid = (state == RUN) && stream_q;
  end

  assign term     = a;
  assign term_idx = idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a        <= '0;
      b        <= '0;
      a_tag    <= 1'b0;
      b_tag    <= 1'b0;
      idx      <= '0;
      n_q      <= '0;
      stream_q <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        n_q      <= n;
        stream_q <= stream_mode;
        a        <= seed0;
        b        <= seed1;
        a_tag    <= 1'b0;
        b_tag    <= 1'b0;
        idx      <= '0;
        overflow <= 1'b0;
      end else if (advance) begin
        a        <= b;
        a_tag    <= b_tag;
        b        <= sum;
        b_tag    <= carry;
        idx      <= idx + 1'b1;
        overflow <= overflow | a_tag;
      end else if (finish) begin
        result   <= a;
        overflow <= overflow | a_tag;
      end
    end
  end

endmodule

// File: tb/tb_fib_seq_engine.sv
// Randomized bench for fib_seq_engine: three instances (16-bit wrap, 8-bit wrap,
// 8-bit saturate) share one control stream and are checked against an arithmetic model.
module tb_fib_seq_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, streamMode, termReady;
  logic [7:0]  nIn;
  logic [15:0] seed0, seed1;

  logic        busyV[3], validV[3], doneV[3], ovfV[3];
  logic [7:0]  idxV[3];
  logic [15:0] term16, res16;
  logic [7:0]  term8w, res8w, term8s, res8s;

  int checks = 0;
  int errors = 0;

  longint mTerm[3][0:256];
  bit     mTag[3][0:256];
  int     wid[3];
  bit     satV[3];
  longint prevRes[3];

  always #5 clk = ~clk;

  fib_seq_engine #(.WIDTH(16), .CNT_W(8), .SATURATE(1'b0)) u16 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .n(nIn),
    .seed0(seed0), .seed1(seed1), .stream_mode(streamMode), .term_ready(termReady),
    .busy(busyV[0]), .term_valid(validV[0]), .term(term16), .term_idx(idxV[0]),
    .done(doneV[0]), .result(res16), .overflow(ovfV[0]));

  fib_seq_engine #(.WIDTH(8), .CNT_W(8), .SATURATE(1'b0)) u8w (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .n(nIn),
    .seed0(seed0[7:0]), .seed1(seed1[7:0]), .stream_mode(streamMode), .term_ready(termReady),
    .busy(busyV[1]), .term_valid(validV[1]), .term(term8w), .term_idx(idxV[1]),
    .done(doneV[1]), .result(res8w), .overflow(ovfV[1]));

  fib_seq_engine #(.WIDTH(8), .CNT_W(8), .SATURATE(1'b1)) u8s (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .n(nIn),
    .seed0(seed0[7:0]), .seed1(seed1[7:0]), .stream_mode(streamMode), .term_ready(termReady),
    .busy(busyV[2]), .term_valid(validV[2]), .term(term8s), .term_idx(idxV[2]),
    .done(doneV[2]), .result(res8s), .overflow(ovfV[2]));

  function automatic longint obsTerm(int d);
    case (d)
      0:       return longint'(term16);
      1:       return longint'(term8w);
      default: return longint'(term8s);
    endcase
  endfunction

  function automatic longint obsResult(int d);
    case (d)
      0:       return longint'(res16);
      1:       return longint'(res8w);
      default: return longint'(res8s);
    endcase
  endfunction

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Plain arithmetic model: full-precision sum, then wrap or clamp per instance
  task automatic buildModel(input longint s0, input longint s1, input int n);
    for (int d = 0; d < 3; d++) begin
      longint mask = (longint'(1) << wid[d]) - 1;
      mTerm[d][0] = s0 & mask; mTag[d][0] = 1'b0;
      mTerm[d][1] = s1 & mask; mTag[d][1] = 1'b0;
      for (int k = 2; k <= n; k++) begin
        longint s = mTerm[d][k-1] + mTerm[d][k-2];
        mTag[d][k]  = (s > mask);
        mTerm[d][k] = (s > mask) ? (satV[d] ? mask : (s & mask)) : s;
      end
    end
  endtask

  function automatic longint ovfUpTo(int d, int upto);
    longint r = 0;
    for (int k = 0; k <= upto; k++) if (mTag[d][k]) r = 1;
    return r;
  endfunction

  task automatic checkIdleAll(input string tag, input bit expDone);
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("%s_busy_d%0d", tag, d), longint'(busyV[d]), 0);
      checkOutput($sformatf("%s_valid_d%0d", tag, d), longint'(validV[d]), 0);
      checkOutput($sformatf("%s_done_d%0d", tag, d), longint'(doneV[d]), longint'(expDone));
    end
  endtask

  // readyMode: 0 always ready, 1 random, 2 stall three cycles at idx 2
  task automatic applyStimulus(input int s0, input int s1, input int n, input bit strm,
                               input int readyMode, input int abortAt, input bit startNoise);
    int  k = 0, cyc = 0, stall = 0;
    bit  rdy, aborted = 0;
    buildModel(longint'(s0), longint'(s1), n);
    seed0 = 16'(s0); seed1 = 16'(s1); nIn = 8'(n); streamMode = strm;
    start = 1'b1; abort = 1'b0; termReady = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    seed0 = 16'($urandom); seed1 = 16'($urandom); nIn = 8'($urandom); streamMode = ~strm;
    while (k <= n) begin
      if (cyc > 4000) begin
        checkOutput("timeout", 1, 0);
        return;
      end
      for (int d = 0; d < 3; d++) begin
        checkOutput($sformatf("run_busy_d%0d_k%0d", d, k), longint'(busyV[d]), 1);
        checkOutput($sformatf("run_done_d%0d_k%0d", d, k), longint'(doneV[d]), 0);
        checkOutput($sformatf("run_valid_d%0d_k%0d", d, k), longint'(validV[d]), longint'(strm));
        if (strm) begin
          checkOutput($sformatf("term_d%0d_k%0d", d, k), obsTerm(d), mTerm[d][k]);
          checkOutput($sformatf("idx_d%0d_k%0d", d, k), longint'(idxV[d]), longint'(k));
        end
      end
      if (readyMode == 0)      rdy = 1'b1;
      else if (readyMode == 1) rdy = ($urandom_range(0, 3) != 0);
      else begin
        rdy = !(k == 2 && stall < 3);
        if (!rdy) stall++;
      end
      termReady = rdy;
      start = startNoise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (k == abortAt) abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0; start = 1'b0;
      if (k == abortAt) begin
        aborted = 1;
        break;
      end
      if (!strm || rdy) k++;
      cyc++;
    end
    termReady = 1'b0;
    if (aborted) begin
      checkIdleAll("abort", 1'b0);
      for (int d = 0; d < 3; d++) begin
        checkOutput($sformatf("abort_result_d%0d", d), obsResult(d), prevRes[d]);
        checkOutput($sformatf("abort_ovf_d%0d", d), longint'(ovfV[d]), ovfUpTo(d, k - 1));
      end
    end else begin
      checkIdleAll("fin", 1'b1);
      for (int d = 0; d < 3; d++) begin
        checkOutput($sformatf("fin_result_d%0d", d), obsResult(d), mTerm[d][n]);
        checkOutput($sformatf("fin_ovf_d%0d", d), longint'(ovfV[d]), ovfUpTo(d, n));
        prevRes[d] = mTerm[d][n];
      end
      @(posedge clk); #1;
      checkIdleAll("post", 1'b0);
      for (int d = 0; d < 3; d++)
        checkOutput($sformatf("post_result_d%0d", d), obsResult(d), prevRes[d]);
    end
  endtask

  initial begin
    wid  = '{16, 8, 8};
    satV = '{1'b0, 1'b0, 1'b1};
    prevRes = '{0, 0, 0};
    rst = 1'b1; start = 1'b0; abort = 1'b0; streamMode = 1'b0; termReady = 1'b0;
    nIn = '0; seed0 = '0; seed1 = '0;
    repeat (2) @(posedge clk);
    #1;
    checkIdleAll("reset", 1'b0);
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("reset_result_d%0d", d), obsResult(d), 0);
      checkOutput($sformatf("reset_ovf_d%0d", d), longint'(ovfV[d]), 0);
      checkOutput($sformatf("reset_term_d%0d", d), obsTerm(d), 0);
      checkOutput($sformatf("reset_idx_d%0d", d), longint'(idxV[d]), 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(0, 1, 10, 1'b0, 0, -1, 1'b0);
    checkOutput("fib10_result", obsResult(0), 55);
    applyStimulus(2, 1, 5, 1'b1, 0, -1, 1'b0);
    checkOutput("stream5_result", obsResult(0), 11);
    applyStimulus(2, 1, 5, 1'b1, 2, -1, 1'b0);
    applyStimulus(0, 1, 13, 1'b0, 0, -1, 1'b0);
    checkOutput("w8_n13_result", obsResult(1), 233);
    checkOutput("w8_n13_ovf", longint'(ovfV[1]), 0);
    applyStimulus(0, 1, 14, 1'b1, 1, -1, 1'b0);
    checkOutput("w8_n14_wrap_result", obsResult(1), 121);
    checkOutput("w8_n14_wrap_ovf", longint'(ovfV[1]), 1);
    checkOutput("w8_n14_sat_result", obsResult(2), 255);
    checkOutput("w8_n14_sat_ovf", longint'(ovfV[2]), 1);
    applyStimulus(0, 1, 10, 1'b0, 0, 3, 1'b1);
    applyStimulus(3, 4, 6, 1'b1, 0, 6, 1'b0);

    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checkIdleAll("idle_abort", 1'b0);
    for (int d = 0; d < 3; d++)
      checkOutput($sformatf("idle_abort_result_d%0d", d), obsResult(d), prevRes[d]);

    for (int t = 0; t < 40; t++) begin
      int n = $urandom_range(0, 30);
      int ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n)) : -1;
      applyStimulus(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), n,
                    1'($urandom_range(0, 1)), 1, ab, 1'($urandom_range(0, 1)));
    end

    seed0 = 16'd9; seed1 = 16'd4; nIn = 8'd20; streamMode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkIdleAll("midrst", 1'b0);
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("midrst_result_d%0d", d), obsResult(d), 0);
      checkOutput($sformatf("midrst_ovf_d%0d", d), longint'(ovfV[d]), 0);
      checkOutput($sformatf("midrst_term_d%0d", d), obsTerm(d), 0);
      checkOutput($sformatf("midrst_idx_d%0d", d), longint'(idxV[d]), 0);
      prevRes[d] = 0;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(7, 5, 0, 1'b0, 0, -1, 1'b0);
    checkOutput("n0_result", obsResult(0), 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
